// File: rtl/spi_pkg.sv
// Shared definitions for the SPI link blocks: FSM state encoding and
// counter sizing helper.
package spi_pkg;

  typedef enum logic [3:0] {
    STATE_WAIT_RELEASE = 4'd0,
    STATE_IDLE         = 4'd1,
    STATE_SHIFT        = 4'd2
  } state_t;

  // Counter must hold 0..bit_count+1, where bit_count+1 flags an overrun.
  function automatic int cnt_width(input int bit_count);
    return $clog2(bit_count + 2);
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous serial line, followed by a
// history flop that yields registered rise/fall pulses aligned with level.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a real shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  // Level is taken from the history stage so it lines up with the pulses.
  assign level = hist_q;

endmodule

// File: rtl/spi_deserializer.sv
// SPI receiver: oversamples SPI_clk/CS/DataBit on clk, shifts in MSB-first
// frames and publishes each correctly sized frame on CS release.
module spi_deserializer
  import spi_pkg::*;
#(
  parameter int Register_Width = 32,
  parameter int Shift_BitCount = 24,
  parameter bit CS_ACTIVE_LOW  = 1'b1,
  parameter bit SAMPLE_RISING  = 1'b1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SPI_clk,
  input  logic                      CS,
  input  logic                      DataBit,
  output logic [Register_Width-1:0] Data_Register,
  output logic                      Data_Valid,
  output logic                      Frame_Error
);

  localparam int CNT_W = cnt_width(Shift_BitCount);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(Shift_BitCount);
  localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(Shift_BitCount + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise_unused, cs_fall_unused;
  logic data_level, data_rise_unused, data_fall_unused;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(SPI_clk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(CS),
    .level(cs_level), .rise(cs_rise_unused), .fall(cs_fall_unused)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst(rst), .din(DataBit),
    .level(data_level), .rise(data_rise_unused), .fall(data_fall_unused)
  );

  logic cs_active;
  logic sample_edge;
  assign cs_active   = CS_ACTIVE_LOW ? ~cs_level : cs_level;
  assign sample_edge = SAMPLE_RISING ? sclk_rise : sclk_fall;

  state_t                    state;
  logic [Shift_BitCount-1:0] shift_reg;
  logic [CNT_W-1:0]          bit_cnt;
  logic [Shift_BitCount:0]   shift_ext;

  // Widening before truncation keeps the shift legal for one-bit frames.
  assign shift_ext = {shift_reg, data_level};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= STATE_WAIT_RELEASE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      Data_Register <= '0;
      Data_Valid    <= 1'b0;
      Frame_Error   <= 1'b0;
    end else begin
      Data_Valid  <= 1'b0;
      Frame_Error <= 1'b0;
      case (state)
        STATE_WAIT_RELEASE: begin
          if (!cs_active) state <= STATE_IDLE;
        end
        STATE_IDLE: begin
          bit_cnt <= '0;
          if (cs_active) begin
            shift_reg <= '0;
            state     <= STATE_SHIFT;
          end
        end
        STATE_SHIFT: begin
          // Release takes priority over a coincident sample edge.
          if (!cs_active) begin
            state <= STATE_IDLE;
            if (bit_cnt == CNT_FULL) begin
              Data_Register <= Register_Width'(shift_reg);
              Data_Valid    <= 1'b1;
            end else begin
              Frame_Error <= 1'b1;
            end
          end else if (sample_edge) begin
            shift_reg <= shift_ext[Shift_BitCount-1:0];
            if (bit_cnt != CNT_OVERRUN) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= STATE_WAIT_RELEASE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// Randomized self-checking bench for spi_deserializer: two instances cover
// both CS polarities and both sample edges.
module tb_spi_deserializer;

  localparam int RW = 32;
  localparam int NB = 24;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;
  logic sclk0, cs0, din0, sclk1, cs1, din1;
  logic [RW-1:0] dr0, dr1;
  logic dv0, fe0, dv1, fe1;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] words0[$];
  logic [RW-1:0] words1[$];
  int fe_cnt0 = 0, fe_cnt1 = 0;
  logic prev_dv0 = 0, prev_fe0 = 0, prev_dv1 = 0, prev_fe1 = 0;
  logic [RW-1:0] last_good0 = '0;

  always #5 clk = ~clk;

  spi_deserializer #(.Register_Width(RW), .Shift_BitCount(NB),
                     .CS_ACTIVE_LOW(1'b1), .SAMPLE_RISING(1'b1),
                     .SYNC_STAGES(SS)) dut0 (
    .clk(clk), .rst(rst), .SPI_clk(sclk0), .CS(cs0), .DataBit(din0),
    .Data_Register(dr0), .Data_Valid(dv0), .Frame_Error(fe0)
  );

  spi_deserializer #(.Register_Width(RW), .Shift_BitCount(NB),
                     .CS_ACTIVE_LOW(1'b0), .SAMPLE_RISING(1'b0),
                     .SYNC_STAGES(SS)) dut1 (
    .clk(clk), .rst(rst), .SPI_clk(sclk1), .CS(cs1), .DataBit(din1),
    .Data_Register(dr1), .Data_Valid(dv1), .Frame_Error(fe1)
  );

  // Event monitor: logs published words/errors and checks pulse shape.
  always @(negedge clk) begin
    if (dv0) words0.push_back(dr0);
    if (fe0) fe_cnt0++;
    if (dv1) words1.push_back(dr1);
    if (fe1) fe_cnt1++;
    if (dv0 || fe0) begin
      checks++;
      if ((dv0 && fe0) || (dv0 && prev_dv0) || (fe0 && prev_fe0)) begin
        errors++;
        $display("FAIL pulse_shape0 dv=%b fe=%b prev_dv=%b prev_fe=%b, required single exclusive pulses",
                 dv0, fe0, prev_dv0, prev_fe0);
      end
    end
    if (dv1 || fe1) begin
      checks++;
      if ((dv1 && fe1) || (dv1 && prev_dv1) || (fe1 && prev_fe1)) begin
        errors++;
        $display("FAIL pulse_shape1 dv=%b fe=%b prev_dv=%b prev_fe=%b, required single exclusive pulses",
                 dv1, fe1, prev_dv1, prev_fe1);
      end
    end
    prev_dv0 = dv0; prev_fe0 = fe0; prev_dv1 = dv1; prev_fe1 = fe1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input int which, input logic active);
    if (which == 0) cs0 = ~active; else cs1 = active;
  endtask

  task automatic set_sclk(input int which, input logic v);
    if (which == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic set_din(input int which, input logic v);
    if (which == 0) din0 = v; else din1 = v;
  endtask

  // Data is held across both SPI_clk edges so either sample edge sees it.
  task automatic drive_frame(input int which, input int nbits, input logic [63:0] value,
                             input int half, input int rst_bit);
    set_cs(which, 1'b1);
    wait_cyc(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
      end
      set_din(which, value[i]);
      wait_cyc(half);
      set_sclk(which, 1'b1);
      wait_cyc(half);
      set_sclk(which, 1'b0);
      wait_cyc(half);
    end
    set_cs(which, 1'b0);
  endtask

  function automatic logic [RW-1:0] model_word(input logic [63:0] value);
    return RW'(value % (64'd1 << NB));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(3);
    checks++;
    if (dr0 !== '0 || dv0 !== 1'b0 || fe0 !== 1'b0 || dr1 !== '0 || dv1 !== 1'b0 || fe1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state dr0=%h dv0=%b fe0=%b dr1=%h dv1=%b fe1=%b, required all zero",
               dr0, dv0, fe0, dr1, dv1, fe1);
    end
    rst = 1'b0;
    wait_cyc(10);
    checks++;
    if (words0.size() != 0 || fe_cnt0 != 0 || words1.size() != 0 || fe_cnt1 != 0) begin
      errors++;
      $display("FAIL reset_quiet words0=%0d fe0=%0d words1=%0d fe1=%0d, required 0",
               words0.size(), fe_cnt0, words1.size(), fe_cnt1);
    end
  endtask

  task automatic test_basic_latency();
    int lat = -1;
    drive_frame(0, NB, 64'hA5C3F0, 8, -1);
    for (int k = 1; k <= 12; k++) begin
      wait_cyc(1);
      if (dv0 && lat < 0) lat = k;
    end
    last_good0 = model_word(64'hA5C3F0);
    checks++;
    if (lat != SS + 2) begin
      errors++;
      $display("FAIL basic_latency got %0d cycles, required %0d", lat, SS + 2);
    end
    checks++;
    if (words0.size() != 1 || dr0 !== last_good0 || fe_cnt0 != 0) begin
      errors++;
      $display("FAIL basic_word pulses=%0d dr=%h fe=%0d, required 1 pulse dr=%h fe=0",
               words0.size(), dr0, fe_cnt0, last_good0);
    end
    words0.delete();
  endtask

  task automatic test_short_frame();
    int fe_snap;
    drive_frame(0, NB, 64'h123456, 5, -1);
    wait_cyc(12);
    last_good0 = model_word(64'h123456);
    checks++;
    if (words0.size() != 1 || dr0 !== last_good0) begin
      errors++;
      $display("FAIL short_pre pulses=%0d dr=%h, required 1 pulse dr=%h", words0.size(), dr0, last_good0);
    end
    words0.delete();
    fe_snap = fe_cnt0;
    drive_frame(0, NB - 1, 64'($urandom), 5, -1);
    wait_cyc(12);
    checks++;
    if (fe_cnt0 != fe_snap + 1 || words0.size() != 0 || dr0 !== last_good0) begin
      errors++;
      $display("FAIL short_frame fe=%0d pulses=%0d dr=%h, required fe=%0d 0 pulses dr=%h",
               fe_cnt0 - fe_snap, words0.size(), dr0, 1, last_good0);
    end
  endtask

  task automatic test_overrun();
    int fe_snap = fe_cnt0;
    drive_frame(0, NB + 1, 64'h1FFFFFF, 5, -1);
    wait_cyc(12);
    checks++;
    if (fe_cnt0 != fe_snap + 1 || words0.size() != 0 || dr0 !== last_good0) begin
      errors++;
      $display("FAIL overrun fe=%0d pulses=%0d dr=%h, required fe=1 0 pulses dr=%h",
               fe_cnt0 - fe_snap, words0.size(), dr0, last_good0);
    end
    drive_frame(0, NB, 64'h000001, 5, -1);
    wait_cyc(12);
    last_good0 = model_word(64'h000001);
    checks++;
    if (words0.size() != 1 || dr0 !== last_good0 || fe_cnt0 != fe_snap + 1) begin
      errors++;
      $display("FAIL after_overrun pulses=%0d dr=%h, required 1 pulse dr=%h", words0.size(), dr0, last_good0);
    end
    words0.delete();
  endtask

  task automatic test_reset_midframe();
    int fe_snap = fe_cnt0;
    drive_frame(0, NB, 64'($urandom), 5, 10);
    wait_cyc(12);
    last_good0 = '0;
    checks++;
    if (words0.size() != 0 || fe_cnt0 != fe_snap || dr0 !== last_good0) begin
      errors++;
      $display("FAIL reset_midframe pulses=%0d fe=%0d dr=%h, required 0 pulses fe=0 dr=0",
               words0.size(), fe_cnt0 - fe_snap, dr0);
    end
    drive_frame(0, NB, 64'hFFFFFF, 5, -1);
    wait_cyc(12);
    last_good0 = model_word(64'hFFFFFF);
    checks++;
    if (words0.size() != 1 || dr0 !== last_good0) begin
      errors++;
      $display("FAIL after_reset pulses=%0d dr=%h, required 1 pulse dr=%h", words0.size(), dr0, last_good0);
    end
    words0.delete();
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] w0, w1;
    drive_frame(0, NB, 64'h0F0F0F, 4, -1);
    wait_cyc(4);
    drive_frame(0, NB, 64'hF0F0F0, 4, -1);
    wait_cyc(12);
    checks++;
    if (words0.size() != 2) begin
      errors++;
      $display("FAIL b2b_count pulses=%0d, required 2", words0.size());
    end else begin
      w0 = words0[0];
      w1 = words0[1];
      checks++;
      if (w0 !== model_word(64'h0F0F0F) || w1 !== model_word(64'hF0F0F0)) begin
        errors++;
        $display("FAIL b2b_words got %h,%h, required %h,%h", w0, w1,
                 model_word(64'h0F0F0F), model_word(64'hF0F0F0));
      end
    end
    last_good0 = model_word(64'hF0F0F0);
    words0.delete();
  endtask

  task automatic test_random();
    int nbits, half, fe_snap, r;
    logic [63:0] value;
    for (int f = 0; f < 20; f++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) nbits = NB;
      else if (r == 6) nbits = NB - 1;
      else if (r == 7) nbits = NB + 1;
      else if (r == 8) nbits = 0;
      else nbits = int'($urandom_range(1, NB - 2));
      value = {32'($urandom), 32'($urandom)} % (64'd1 << nbits);
      half  = int'($urandom_range(4, 6));
      fe_snap = fe_cnt0;
      drive_frame(0, nbits, value, half, -1);
      wait_cyc(12);
      if (nbits == NB) last_good0 = model_word(value);
      checks++;
      if (words0.size() != ((nbits == NB) ? 1 : 0) ||
          fe_cnt0 - fe_snap != ((nbits == NB) ? 0 : 1) || dr0 !== last_good0) begin
        errors++;
        $display("FAIL random_frame%0d len=%0d pulses=%0d fe=%0d dr=%h, required dr=%h",
                 f, nbits, words0.size(), fe_cnt0 - fe_snap, dr0, last_good0);
      end
      words0.delete();
    end
  endtask

  task automatic test_falling_active_high();
    drive_frame(1, NB, 64'h800001, 5, -1);
    wait_cyc(12);
    checks++;
    if (words1.size() != 1 || dr1 !== model_word(64'h800001) || fe_cnt1 != 0) begin
      errors++;
      $display("FAIL falling_cs_high pulses=%0d dr=%h fe=%0d, required 1 pulse dr=%h fe=0",
               words1.size(), dr1, fe_cnt1, model_word(64'h800001));
    end
  endtask

  initial begin
    rst = 1'b1;
    sclk0 = 1'b0; cs0 = 1'b1; din0 = 1'b0;
    sclk1 = 1'b0; cs1 = 1'b0; din1 = 1'b0;
    test_reset();
    test_basic_latency();
    test_short_frame();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    test_falling_active_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
